init_fill: RTL
==============

Name: init_fill

Overview:
- Parametrised memory-initialisation engine, successor to the fixed 256-entry identity initialiser used ahead of the ARC4 key-schedule.
- Writes a programmable run of words into a single-port RAM.
- Supports configurable depth and width, start address with wrap-around, run length, four data-generation modes, write back-pressure (stall) and abort.
- Sits between the top-level controller and the S-memory write port.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- DEPTH, 256, number of memory words; 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- mode  in  2  data mode: 0 identity, 1 constant, 2 reverse, 3 xor.
- start_addr  in  ADDR_W  first address.
- len  in  ADDR_W+1  number of writes; 0 or >DEPTH means DEPTH.
- fill_val  in  DATA_W  constant/xor operand.
- stall  in  1  memory port busy; current beat is not committed.
- abort  in  1  terminate run early.
- rdy  out  1  idle, able to accept en.
- addr  out  ADDR_W  write address (registered).
- wrdata  out  DATA_W  write data (registered).
- wren  out  1  write enable (registered).
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, any state): state IDLE; rdy=1, wren=0, addr=0, wrdata=0, done=0; internal counters 0.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, WRITE.

IDLE:
- rdy=1, wren=0.
- Edge with en=1: latch mode, fill_val, a0 and L.
  - a0 = start_addr if start_addr < DEPTH, else 0.
  - L = DEPTH if len == 0 or len > DEPTH, else len.
- On that same edge: rdy<=0, wren<=1, addr<=a0, wrdata<=f(a0), remaining<=L, state<=WRITE.
- abort is ignored in IDLE.

Data function f(a), with a zero-extended or truncated to DATA_W:
- mode 0: a.
- mode 1: fill_val.
- mode 2: DEPTH-1-a.
- mode 3: a XOR fill_val.

WRITE:
- A beat commits on an edge where wren=1 and stall=0.
- Edge with abort=1: wren<=0, rdy<=1, done stays 0, state<=IDLE. abort takes priority over stall and over completion.
- Edge with stall=1 (no abort): addr, wrdata, wren and remaining all hold.
- Committed beat with remaining>1:
  - addr<=next(addr), where next(a) = 0 if a == DEPTH-1, else a+1.
  - wrdata<=f(next(addr)); remaining decrements.
- Committed beat with remaining==1: wren<=0, done<=1, rdy<=1, state<=IDLE.
- en is ignored while rdy=0.

Timing:
- done is high for exactly one cycle, coincident with the first cycle of rdy=1.
- A new en may be accepted on the edge that ends the done cycle (back-to-back runs).
- Throughput: one write per cycle with stall=0. A run takes L cycles of wren=1, plus stall cycles.
- Addresses wrap modulo DEPTH; a run of L=DEPTH visits every address exactly once.
- Config inputs are don't-care outside the en acceptance edge.

Test Plan:
- Default parameters, en=1, mode=0, start_addr=0, len=0:
  - wren high 256 cycles; writes (0,0)…(255,255).
  - done pulse the cycle wren falls; rdy=1 same cycle.
- mode=1, fill_val=8'hA5, start_addr=250, len=10:
  - addresses 250..255 then 0..3, all data 8'hA5; exactly 10 writes.
- mode=3, fill_val=8'h0F, start_addr=0x10, len=4, stall=1 on the 2nd and 3rd beats for 2 cycles each:
  - committed writes (10,1F),(11,1E),(12,1D),(13,1C).
  - held outputs are stable while stalled; total wren-high cycles = 8.
- DEPTH=200, ADDR_W=8, mode=2, start_addr=240, len=300:
  - start clamps to 0 and len clamps to 200.
  - writes (0,199)…(199,0); no address ≥200 ever appears.
- Abort after 5 committed beats: wren=0 and rdy=1 next edge, done never asserts. en pulsed during the run is ignored.
- Assert rst mid-run, asynchronously between edges: outputs go to reset values immediately; after release, a fresh en starts normally.

Source files
------------

// File: rtl/init_fill_if.sv
// init_fill_if: controller/write-port bundle for the init_fill memory initialiser.
interface init_fill_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              en;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   len;
   logic [DATA_W-1:0] fill_val;
   logic              stall;
   logic              abort;
   logic              rdy;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wrdata;
   logic              wren;
   logic              done;
   modport master (output en, mode, start_addr, len, fill_val, stall, abort,
                   input  rdy, addr, wrdata, wren, done);
   modport slave  (input  en, mode, start_addr, len, fill_val, stall, abort,
                   output rdy, addr, wrdata, wren, done);
endinterface

// File: rtl/init_fill.sv
// init_fill: writes a programmable, wrapping run of generated words into a single-port RAM,
// one beat per cycle with stall back-pressure and abort.
module init_fill #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input logic       clk,
   input logic       rst,
   init_fill_if.slave bus
);
   typedef enum logic {IDLE, WRITE} state_e;
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   state_e            state_q;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] fill_q;
   logic [ADDR_W:0]   rem_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wrdata_q;
   logic              wren_q;
   logic              rdy_q;
   logic              done_q;
   logic [ADDR_W-1:0] a0_d;
   logic [ADDR_W:0]   len_d;
   logic [ADDR_W-1:0] next_d;
   function automatic logic [DATA_W-1:0] gen(input logic [1:0] m, input logic [DATA_W-1:0] v,
                                             input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] ax;
      logic [DATA_W-1:0] rv;
      ax = DATA_W'(a);
      rv = DATA_W'(LAST - a);
      return m == 2'd0 ? ax : m == 2'd1 ? v : m == 2'd2 ? rv : ax ^ v;
   endfunction
   assign a0_d   = (ADDR_W + 1)'(bus.start_addr) < DEPTH_L ? bus.start_addr : '0;
   assign len_d  = (bus.len == '0 || bus.len > DEPTH_L) ? DEPTH_L : bus.len;
   assign next_d = addr_q == LAST ? '0 : addr_q + ADDR_W'(1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= '0;
         fill_q   <= '0;
         rem_q    <= '0;
         addr_q   <= '0;
         wrdata_q <= '0;
         wren_q   <= 1'b0;
         rdy_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.en) begin
                  mode_q   <= bus.mode;
                  fill_q   <= bus.fill_val;
                  rem_q    <= len_d;
                  addr_q   <= a0_d;
                  wrdata_q <= gen(bus.mode, bus.fill_val, a0_d);
                  wren_q   <= 1'b1;
                  rdy_q    <= 1'b0;
                  state_q  <= WRITE;
               end
            end
            WRITE: begin
               // abort wins over both stall and completion
               if (bus.abort) begin
                  wren_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (!bus.stall) begin
                  if (rem_q == (ADDR_W + 1)'(1)) begin
                     wren_q  <= 1'b0;
                     done_q  <= 1'b1;
                     rdy_q   <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     addr_q   <= next_d;
                     wrdata_q <= gen(mode_q, fill_q, next_d);
                     rem_q    <= rem_q - (ADDR_W + 1)'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.rdy    = rdy_q;
   assign bus.addr   = addr_q;
   assign bus.wrdata = wrdata_q;
   assign bus.wren   = wren_q;
   assign bus.done   = done_q;
endmodule
